// File: rtl/id_ex_stage_if.sv
// ID->EX pipeline register bus: decoder-side inputs, EX-side registered outputs and stall.
// The master modport is the ID/control side; the slave modport is the pipeline register.
interface id_ex_stage_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 16
);
  localparam int unsigned CTRL_W = 9;
  localparam int unsigned REG_W  = 5;

  logic              id_valid;
  logic [CTRL_W-1:0] id_ctrl;
  logic [WIDTH-1:0]  id_rd1;
  logic [WIDTH-1:0]  id_rd2;
  logic [WIDTH-1:0]  id_imm;
  logic [WIDTH-1:0]  id_pc4;
  logic [REG_W-1:0]  id_rs;
  logic [REG_W-1:0]  id_rt;
  logic [REG_W-1:0]  id_rd;
  logic              flush;
  logic              ex_hold;

  logic              stall_o;
  logic              ex_valid;
  logic [CTRL_W-1:0] ex_ctrl;
  logic [WIDTH-1:0]  ex_rd1;
  logic [WIDTH-1:0]  ex_rd2;
  logic [WIDTH-1:0]  ex_imm;
  logic [WIDTH-1:0]  ex_pc4;
  logic [REG_W-1:0]  ex_rs;
  logic [REG_W-1:0]  ex_rt;
  logic [REG_W-1:0]  ex_rd;
  logic [CNT_W-1:0]  bubble_count;

  modport master (
    output id_valid, id_ctrl, id_rd1, id_rd2, id_imm, id_pc4,
    output id_rs, id_rt, id_rd, flush, ex_hold,
    input  stall_o, ex_valid, ex_ctrl, ex_rd1, ex_rd2, ex_imm, ex_pc4,
    input  ex_rs, ex_rt, ex_rd, bubble_count
  );

  modport slave (
    input  id_valid, id_ctrl, id_rd1, id_rd2, id_imm, id_pc4,
    input  id_rs, id_rt, id_rd, flush, ex_hold,
    output stall_o, ex_valid, ex_ctrl, ex_rd1, ex_rd2, ex_imm, ex_pc4,
    output ex_rs, ex_rt, ex_rd, bubble_count
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID->EX pipeline register with load-use hazard detection, bubble insertion,
// branch flush, downstream hold and a saturating count of load-use bubbles.
module id_ex_stage #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  id_ex_stage_if.slave bus
);
  localparam int unsigned CTRL_W     = 9;
  localparam int unsigned REG_W      = 5;
  localparam int unsigned MEMWRITE_B = 7;
  localparam int unsigned BRANCH_B   = 5;
  localparam int unsigned REGDST_B   = 4;
  localparam int unsigned MEMREAD_B  = 2;

  logic              ex_valid_q;
  logic [CTRL_W-1:0] ex_ctrl_q;
  logic [WIDTH-1:0]  ex_rd1_q;
  logic [WIDTH-1:0]  ex_rd2_q;
  logic [WIDTH-1:0]  ex_imm_q;
  logic [WIDTH-1:0]  ex_pc4_q;
  logic [REG_W-1:0]  ex_rs_q;
  logic [REG_W-1:0]  ex_rt_q;
  logic [REG_W-1:0]  ex_rd_q;
  logic [CNT_W-1:0]  bubble_count_q;

  logic uses_rt;
  logic rt_match;
  logic hazard;

  // Load in EX whose destination (rt) is read by the instruction in ID.
  always_comb begin
    uses_rt  = bus.id_ctrl[REGDST_B] | bus.id_ctrl[BRANCH_B] | bus.id_ctrl[MEMWRITE_B];
    rt_match = (ex_rt_q == bus.id_rs) | (uses_rt & (ex_rt_q == bus.id_rt));
    hazard   = bus.id_valid & ex_valid_q & ex_ctrl_q[MEMREAD_B]
             & (ex_rt_q != '0) & rt_match;
  end

  // A flushed ID instruction never needs to stall, so flush masks the hazard stall.
  assign bus.stall_o = bus.ex_hold | (hazard & ~bus.flush);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_valid_q     <= 1'b0;
      ex_ctrl_q      <= '0;
      ex_rd1_q       <= '0;
      ex_rd2_q       <= '0;
      ex_imm_q       <= '0;
      ex_pc4_q       <= '0;
      ex_rs_q        <= '0;
      ex_rt_q        <= '0;
      ex_rd_q        <= '0;
      bubble_count_q <= '0;
    end else if (!bus.ex_hold) begin
      if (bus.flush || hazard) begin
        ex_valid_q <= 1'b0;
        ex_ctrl_q  <= '0;
        ex_rd1_q   <= '0;
        ex_rd2_q   <= '0;
        ex_imm_q   <= '0;
        ex_pc4_q   <= '0;
        ex_rs_q    <= '0;
        ex_rt_q    <= '0;
        ex_rd_q    <= '0;
        // Only load-use bubbles are counted; flush takes precedence.
        if (!bus.flush && (bubble_count_q != '1)) begin
          bubble_count_q <= bubble_count_q + CNT_W'(1);
        end
      end else begin
        ex_valid_q <= bus.id_valid;
        ex_ctrl_q  <= bus.id_valid ? bus.id_ctrl : '0;
        ex_rd1_q   <= bus.id_rd1;
        ex_rd2_q   <= bus.id_rd2;
        ex_imm_q   <= bus.id_imm;
        ex_pc4_q   <= bus.id_pc4;
        ex_rs_q    <= bus.id_rs;
        ex_rt_q    <= bus.id_rt;
        ex_rd_q    <= bus.id_rd;
      end
    end
  end

  assign bus.ex_valid     = ex_valid_q;
  assign bus.ex_ctrl      = ex_ctrl_q;
  assign bus.ex_rd1       = ex_rd1_q;
  assign bus.ex_rd2       = ex_rd2_q;
  assign bus.ex_imm       = ex_imm_q;
  assign bus.ex_pc4       = ex_pc4_q;
  assign bus.ex_rs        = ex_rs_q;
  assign bus.ex_rt        = ex_rt_q;
  assign bus.ex_rd        = ex_rd_q;
  assign bus.bubble_count = bubble_count_q;

endmodule
